stream_mux_rr: RTL and testbench

- Parametrised N-channel, W-bit streaming multiplexer with valid/ready handshakes on every input and on the output.
- Two selection modes, chosen at runtime by fix_en:
  - Round-robin arbitration across all valid channels.
  - Fixed selection via sel, which generalises the legacy select-driven mux.
- One registered output stage (1-cycle latency, full throughput).
- Sits between multiple producer streams and a single consumer, e.g. sensor/UART channel aggregation.

---
 rtl/mux_pkg.sv | 22 ++
 rtl/rr_pick.sv | 42 ++++
 rtl/stream_mux_rr.sv | 125 ++++++++++++
 tb/tb_stream_mux_rr.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants, helper function and state type for the round-robin stream mux.
package mux_pkg;

    localparam int DEFAULT_N = 8;
    localparam int DEFAULT_W = 8;

    // Values of fix_en: round-robin arbitration or fixed select
    localparam logic MODE_RR  = 1'b0;
    localparam logic MODE_FIX = 1'b1;

    // Occupancy of the single output register
    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    // Index width that never collapses to zero bits for tiny channel counts
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: picks the first request at or after ptr, wrapping
// around. The request vector is doubled and shifted down by ptr so a plain
// lowest-bit scan yields the offset from ptr.
module rr_pick
    import mux_pkg::*;
#(
    parameter  int N    = DEFAULT_N,
    localparam int SELW = clog2_min1(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic            gnt_valid,
    output logic [SELW-1:0] gnt_idx
);

    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   req_rot;
    int             offset;
    int             idx_sum;

    assign req_dbl = {req, req};
    assign req_rot = N'(req_dbl >> ptr);

    // Lowest set bit of the rotated vector is the winner's distance from ptr
    always_comb begin
        gnt_valid = 1'b0;
        offset    = 0;
        idx_sum   = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                gnt_valid = 1'b1;
                offset    = i;
            end
        end
        idx_sum = int'(ptr) + offset;
        if (idx_sum >= N) begin
            idx_sum = idx_sum - N;
        end
        gnt_idx = SELW'(idx_sum);
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with runtime choice between
// round-robin arbitration and fixed select, feeding a single registered
// output stage that can drain and refill in the same cycle.
module stream_mux_rr
    import mux_pkg::*;
#(
    parameter  int N    = DEFAULT_N,
    parameter  int W    = DEFAULT_W,
    localparam int SELW = clog2_min1(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    input  logic            fix_en,
    input  logic [SELW-1:0] sel,
    output logic [W-1:0]    out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SELW-1:0] out_src
);

    // Valid vector padded to the full select range so that sel values past
    // N-1 land on zero bits and never grant
    localparam int NPAD = 1 << SELW;

    out_state_e      state;
    out_state_e      state_nxt;
    logic [SELW-1:0] ptr;
    logic            rr_valid;
    logic [SELW-1:0] rr_idx;
    logic [NPAD-1:0] valid_pad;
    logic            grant_valid;
    logic [SELW-1:0] grant;
    logic            load_en;
    logic            take;
    logic [W-1:0]    grant_data;

    assign valid_pad = NPAD'(in_valid);
    assign out_valid = (state == OUT_FULL);
    assign load_en   = (state == OUT_EMPTY) | out_ready;
    assign take      = load_en & grant_valid;

    rr_pick #(
        .N(N)
    ) u_rr_pick (
        .req      (in_valid),
        .ptr      (ptr),
        .gnt_valid(rr_valid),
        .gnt_idx  (rr_idx)
    );

    // Choose the candidate channel according to the current mode
    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        if (fix_en == MODE_FIX) begin
            grant_valid = valid_pad[sel];
            grant       = sel;
        end else begin
            grant_valid = rr_valid;
            grant       = rr_idx;
        end
    end

    // One-hot ready back to the winning producer; held off during reset
    always_comb begin
        in_ready = '0;
        for (int k = 0; k < N; k++) begin
            in_ready[k] = !rst && take && (grant == SELW'(k));
        end
    end

    // Route the winning channel's word towards the output register
    always_comb begin
        grant_data = '0;
        for (int k = 0; k < N; k++) begin
            if (grant == SELW'(k)) begin
                grant_data = in_data[k*W +: W];
            end
        end
    end

    // Output register occupancy: refill wins over drain, stall holds
    always_comb begin
        state_nxt = state;
        case (state)
            OUT_EMPTY: begin
                if (take) begin
                    state_nxt = OUT_FULL;
                end
            end
            OUT_FULL: begin
                if (out_ready && !grant_valid) begin
                    state_nxt = OUT_EMPTY;
                end
            end
            default: state_nxt = OUT_EMPTY;
        endcase
    end

    // Occupancy state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= OUT_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture the granted word and advance the round-robin pointer past it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= '0;
            out_src  <= '0;
            ptr      <= '0;
        end else if (take) begin
            out_data <= grant_data;
            out_src  <= grant;
            ptr      <= (grant == SELW'(N - 1)) ? '0 : grant + SELW'(1);
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr: an independent arbitration model predicts
// every grant, pushes the expected word when it is offered and pops it when
// the consumer takes it. A small N=6 instance covers the unreachable select.
module tb_stream_mux_rr;

    localparam int N = 8;
    localparam int W = 8;

    typedef struct {
        int src;
        int data;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic            fix_en;
    logic [2:0]      sel;
    logic [W-1:0]    out_data;
    logic            out_valid;
    logic            out_ready;
    logic [2:0]      out_src;

    logic [47:0]     in_data6;
    logic [5:0]      in_valid6;
    logic [5:0]      in_ready6;
    logic            fix_en6;
    logic [2:0]      sel6;
    logic [7:0]      out_data6;
    logic            out_valid6;
    logic            out_ready6;
    logic [2:0]      out_src6;

    int   checks_total  = 0;
    int   checks_passed = 0;
    bit   m_valid;
    int   m_ptr;
    exp_t sb[$];

    stream_mux_rr #(.N(N), .W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .fix_en   (fix_en),
        .sel      (sel),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_src  (out_src)
    );

    stream_mux_rr #(.N(6), .W(8)) dut6 (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data6),
        .in_valid (in_valid6),
        .in_ready (in_ready6),
        .fix_en   (fix_en6),
        .sel      (sel6),
        .out_data (out_data6),
        .out_valid(out_valid6),
        .out_ready(out_ready6),
        .out_src  (out_src6)
    );

    // Free-running 10-unit clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input longint actual, input longint expected);
        checks_total++;
        if (actual == expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic logic [63:0] ramp(input logic [7:0] base);
        logic [63:0] d;
        for (int k = 0; k < N; k++) begin
            d[k*8 +: 8] = base + 8'(k);
        end
        return d;
    endfunction

    task automatic modelGrant(input logic [7:0] v, input bit fix, input int s,
                              output bit gv, output int g);
        gv = 1'b0;
        g  = 0;
        if (fix) begin
            if (s < N && v[s]) begin
                gv = 1'b1;
                g  = s;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                int k;
                k = (m_ptr + i) % N;
                if (!gv && v[k]) begin
                    gv = 1'b1;
                    g  = k;
                end
            end
        end
    endtask

    // Drive one cycle of stimulus, check against the model, then advance it
    task automatic applyStimulus(input logic [7:0] v, input logic [63:0] d,
                                 input bit fix, input int s, input bit ordy);
        bit          gv;
        int          g;
        bit          load;
        exp_t        e;
        logic [63:0] dv;
        in_valid  = v;
        in_data   = d;
        fix_en    = fix;
        sel       = 3'(s);
        out_ready = ordy;
        #2;
        load = !m_valid || ordy;
        modelGrant(v, fix, s, gv, g);
        checkOutput("out_valid", out_valid, m_valid);
        if (m_valid && sb.size() > 0) begin
            checkOutput("out_data", out_data, sb[0].data);
            checkOutput("out_src", out_src, sb[0].src);
        end
        checkOutput("in_ready", in_ready, (load && gv) ? (64'd1 << g) : 64'd0);
        @(posedge clk);
        #1;
        if (m_valid && ordy && sb.size() > 0) begin
            void'(sb.pop_front());
        end
        if (load && gv) begin
            dv     = d;
            e.src  = g;
            e.data = int'(dv[g*8 +: 8]);
            sb.push_back(e);
            m_valid = 1'b1;
            m_ptr   = (g == N - 1) ? 0 : g + 1;
        end else if (ordy) begin
            m_valid = 1'b0;
        end
    endtask

    // Main stimulus sequence
    initial begin
        rst       = 1'b1;
        in_valid  = 8'hFF;
        in_data   = ramp(8'h00);
        fix_en    = 1'b0;
        sel       = 3'd0;
        out_ready = 1'b1;
        in_data6  = 48'hC5C4C3C2C1C0;
        in_valid6 = 6'h3F;
        fix_en6   = 1'b1;
        sel6      = 3'd7;
        out_ready6 = 1'b1;
        m_valid   = 1'b0;
        m_ptr     = 0;

        #2;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_out_src", out_src, 0);
        checkOutput("rst_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        checkOutput("rst_hold_out_valid", out_valid, 0);
        checkOutput("rst_hold_in_ready", in_ready, 0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) applyStimulus(8'hFF, ramp(8'hA0), 1'b0, 0, 1'b1);

        applyStimulus(8'hFF, ramp(8'h10), 1'b1, 5, 1'b1);
        applyStimulus(8'h05, ramp(8'h20), 1'b0, 0, 1'b1);
        applyStimulus(8'h05, ramp(8'h28), 1'b0, 0, 1'b1);

        applyStimulus(8'hFF, ramp(8'h30), 1'b0, 0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(8'($urandom), {$urandom, $urandom}, 1'b0, 0, 1'b0);
        end
        applyStimulus(8'hFF, ramp(8'h40), 1'b0, 0, 1'b1);

        for (int i = 0; i < 4; i++) applyStimulus(8'hFF, ramp(8'h50), 1'b1, 5, 1'b1);
        applyStimulus(8'hF7, ramp(8'h58), 1'b1, 3, 1'b1);
        applyStimulus(8'hF7, ramp(8'h58), 1'b1, 3, 1'b1);

        for (int i = 0; i < 3; i++) applyStimulus(8'hFF, ramp(8'h60), 1'b0, 0, 1'b1);
        applyStimulus(8'hFF, ramp(8'h68), 1'b1, 4, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(8'hFF, ramp(8'h70), 1'b0, 0, 1'b1);

        for (int i = 0; i < 60; i++) begin
            applyStimulus(8'($urandom), {$urandom, $urandom},
                          ($urandom_range(0, 3) == 0), int'($urandom_range(0, 7)),
                          ($urandom_range(0, 3) != 0));
        end

        applyStimulus(8'hFF, ramp(8'h80), 1'b1, 3, 1'b1);
        applyStimulus(8'hFF, ramp(8'h88), 1'b0, 0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_out_valid", out_valid, 0);
        checkOutput("midrst_out_data", out_data, 0);
        checkOutput("midrst_out_src", out_src, 0);
        checkOutput("midrst_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        checkOutput("midrst_hold_out_valid", out_valid, 0);
        rst     = 1'b0;
        m_valid = 1'b0;
        m_ptr   = 0;
        sb.delete();
        applyStimulus(8'hFF, ramp(8'h90), 1'b0, 0, 1'b1);
        applyStimulus(8'hFF, ramp(8'h98), 1'b0, 0, 1'b1);
        applyStimulus(8'h00, ramp(8'h00), 1'b0, 0, 1'b1);
        applyStimulus(8'h00, ramp(8'h00), 1'b0, 0, 1'b1);

        for (int i = 0; i < 3; i++) begin
            checkOutput("n6_sel7_in_ready", in_ready6, 0);
            checkOutput("n6_sel7_out_valid", out_valid6, 0);
            @(posedge clk);
            #1;
        end
        sel6 = 3'd5;
        #2;
        checkOutput("n6_sel5_in_ready", in_ready6, 6'h20);
        @(posedge clk);
        #1;
        checkOutput("n6_sel5_out_valid", out_valid6, 1);
        checkOutput("n6_sel5_out_src", out_src6, 5);
        checkOutput("n6_sel5_out_data", out_data6, 8'hC5);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
